// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
// State and cause encodings are visible on ports, so their values are fixed explicitly.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        DEBOUNCE = 3'd1,
        RELEASE  = 3'd2,
        RUN      = 3'd3,
        SW_HOLD  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        POR       = 2'd0,
        EXT       = 2'd1,
        LOCK_LOST = 2'd2,
        SW        = 2'd3
    } cause_e;

    localparam int LOCK_CNT_W = 8;

    // One shared counter serves debounce, stage spacing and software hold.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit flop-chain synchroniser for asynchronous level inputs.
// Clears to 0 on reset so an unknown input reads as "not good".
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the chain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset controller: debounces PLL lock and button reset, releases domain resets in order,
// and drops every domain at once on a fault or software request while recording the cause.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS     = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STAGE_DELAY     = 8,
    parameter int SW_HOLD_CYCLES  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ext_rst_n_i,
    input  logic                   pll_locked_i,
    input  logic                   sw_rst_req_i,
    output logic [NUM_DOMAINS-1:0] rst_n_o,
    output logic                   all_ready_o,
    output logic [2:0]             state_o,
    output logic [1:0]             reset_cause_o,
    output logic [7:0]             lock_loss_cnt_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, STAGE_DELAY, SW_HOLD_CYCLES);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    logic w_ext_s;
    logic w_locked_s;
    logic w_good;
    logic w_fault;

    state_e                r_state, w_state_nx;
    cause_e                r_cause, w_cause_nx;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
    logic [IDX_W-1:0]      r_idx, w_idx_nx;
    logic [NUM_DOMAINS-1:0] r_rst_n, w_rst_n_nx;
    logic [LOCK_CNT_W-1:0] r_lock_cnt, w_lock_cnt_nx;
    logic                  r_all_ready;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ext (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (ext_rst_n_i),
        .o_q   (w_ext_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (pll_locked_i),
        .o_q   (w_locked_s)
    );

    assign w_good  = w_locked_s & w_ext_s;
    assign w_fault = ~w_good & ((r_state == RELEASE) | (r_state == RUN) | (r_state == SW_HOLD));

    // Next-state, counter, release mask and cause logic; a fault overrides everything else.
    always_comb begin
        w_state_nx    = r_state;
        w_cause_nx    = r_cause;
        w_cnt_nx      = r_cnt;
        w_idx_nx      = r_idx;
        w_rst_n_nx    = r_rst_n;
        w_lock_cnt_nx = r_lock_cnt;

        case (r_state)
            HOLD: begin
                w_rst_n_nx = '0;
                if (w_good) begin
                    w_state_nx = DEBOUNCE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx   = '0;
                end
            end
            DEBOUNCE: begin
                if (!w_good) begin
                    w_state_nx = HOLD;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    w_state_nx = RELEASE;
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                end else begin
                    w_cnt_nx   = r_cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (r_cnt == CNT_W'(STAGE_DELAY - 1)) begin
                    // Domains fill from bit 0 upward, one per stage interval.
                    w_rst_n_nx = (r_rst_n << 1) | NUM_DOMAINS'(1);
                    w_cnt_nx   = '0;
                    if (r_idx == IDX_W'(NUM_DOMAINS - 1)) begin
                        w_state_nx = RUN;
                        w_idx_nx   = '0;
                    end else begin
                        w_idx_nx   = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (sw_rst_req_i) begin
                    w_state_nx = SW_HOLD;
                    w_cnt_nx   = '0;
                    w_cause_nx = SW;
                    w_rst_n_nx = '0;
                end else begin
                    w_rst_n_nx = '1;
                end
            end
            SW_HOLD: begin
                w_rst_n_nx = '0;
                if (r_cnt == CNT_W'(SW_HOLD_CYCLES - 1)) begin
                    w_state_nx = DEBOUNCE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = HOLD;
                w_cnt_nx   = '0;
                w_idx_nx   = '0;
                w_rst_n_nx = '0;
            end
        endcase

        if (w_fault) begin
            w_state_nx = HOLD;
            w_cnt_nx   = '0;
            w_idx_nx   = '0;
            w_rst_n_nx = '0;
            if (!w_locked_s) begin
                w_cause_nx = LOCK_LOST;
                if (r_lock_cnt != 8'hFF) begin
                    w_lock_cnt_nx = r_lock_cnt + 8'd1;
                end else begin
                    w_lock_cnt_nx = r_lock_cnt;
                end
            end else begin
                w_cause_nx = EXT;
            end
        end else begin
            w_lock_cnt_nx = w_lock_cnt_nx;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HOLD;
            r_cause     <= POR;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rst_n     <= '0;
            r_lock_cnt  <= 8'd0;
            r_all_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cause     <= w_cause_nx;
            r_cnt       <= w_cnt_nx;
            r_idx       <= w_idx_nx;
            r_rst_n     <= w_rst_n_nx;
            r_lock_cnt  <= w_lock_cnt_nx;
            r_all_ready <= (w_state_nx == RUN);
        end
    end

    assign rst_n_o         = r_rst_n;
    assign all_ready_o     = r_all_ready;
    assign state_o         = r_state;
    assign reset_cause_o   = r_cause;
    assign lock_loss_cnt_o = r_lock_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a timestamp-based reference model predicts every
// cycle's outputs, a monitor pops and compares them, plus directed latency/saturation checks.
module tb_reset_sequencer;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 16;
    localparam int DLY  = 8;
    localparam int SWH  = 32;
    localparam int MAXE = 65536;

    logic         clk = 1'b0;
    logic         rst;
    logic         ext_rst_n_i;
    logic         pll_locked_i;
    logic         sw_rst_req_i;
    logic [N-1:0] rst_n_o;
    logic         all_ready_o;
    logic [2:0]   state_o;
    logic [1:0]   reset_cause_o;
    logic [7:0]   lock_loss_cnt_o;

    reset_sequencer #(
        .NUM_DOMAINS(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .STAGE_DELAY(DLY), .SW_HOLD_CYCLES(SWH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ext_rst_n_i     (ext_rst_n_i),
        .pll_locked_i    (pll_locked_i),
        .sw_rst_req_i    (sw_rst_req_i),
        .rst_n_o         (rst_n_o),
        .all_ready_o     (all_ready_o),
        .state_o         (state_o),
        .reset_cause_o   (reset_cause_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int rstn;
        int rdy;
        int cause;
        int lcnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: mode 0 = held, 1 = sequencing since edge t0, 2 = software hold since edge s0.
    bit samp_lock[MAXE];
    bit samp_ext[MAXE];
    int e        = -1;
    int last_rst = -1;
    int m_mode   = 0;
    int t0       = 0;
    int s0       = 0;
    int m_cause  = 0;
    int m_lcnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: dut=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_fault(input bit ls);
        m_mode = 0;
        if (!ls) begin
            m_cause = 2;
            if (m_lcnt < 255) m_lcnt++;
        end else begin
            m_cause = 1;
        end
    endtask

    task automatic model_step();
        bit   ls, es, good;
        int   dp, d;
        exp_t x;
        e++;
        samp_lock[e] = pll_locked_i;
        samp_ext[e]  = ext_rst_n_i;
        if (rst) begin
            m_mode = 0; m_cause = 0; m_lcnt = 0; last_rst = e;
        end else begin
            // Synchronised value seen before this edge is the input sampled SYNC edges ago.
            ls   = (e - SYNC > last_rst) ? samp_lock[e - SYNC] : 1'b0;
            es   = (e - SYNC > last_rst) ? samp_ext[e - SYNC]  : 1'b0;
            good = ls & es;
            dp   = e - 1 - t0;
            if (m_mode == 0) begin
                if (good) begin m_mode = 1; t0 = e; end
            end else if (m_mode == 1) begin
                if (!good) begin
                    if (dp >= DEB) model_fault(ls);
                    else m_mode = 0;
                end else if (dp >= DEB + DLY * N && sw_rst_req_i) begin
                    m_mode = 2; s0 = e; m_cause = 3;
                end
            end else begin
                if (!good) model_fault(ls);
                else if (e - s0 == SWH) begin m_mode = 1; t0 = e; end
            end
        end
        d = e - t0;
        x.rstn = 0;
        if (m_mode == 0) x.st = 0;
        else if (m_mode == 2) x.st = 4;
        else if (d < DEB) x.st = 1;
        else if (d < DEB + DLY * N) x.st = 2;
        else x.st = 3;
        for (int k = 0; k < N; k++)
            if (m_mode == 1 && d >= DEB + DLY * (k + 1)) x.rstn |= (1 << k);
        x.rdy   = (x.st == 3) ? 1 : 0;
        x.cause = m_cause;
        x.lcnt  = m_lcnt;
        sb_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: outputs are valid every cycle; compare just after each active edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check("state",     state_o,         x.st);
                check("rst_n",     rst_n_o,         x.rstn);
                check("all_ready", all_ready_o,     x.rdy);
                check("cause",     reset_cause_o,   x.cause);
                check("lock_cnt",  lock_loss_cnt_o, x.lcnt);
            end
        end
    end

    initial begin
        int rise[N];
        int found;
        rst = 1'b1; ext_rst_n_i = 1'b0; pll_locked_i = 1'b0; sw_rst_req_i = 1'b0;
        tick();                                   // edge 0: reset
        rst = 1'b0; ext_rst_n_i = 1'b1; pll_locked_i = 1'b1;
        for (int k = 0; k < N; k++) rise[k] = -1;
        for (int i = 0; i < 70; i++) begin
            tick();
            for (int k = 0; k < N; k++)
                if (rise[k] < 0 && rst_n_o[k]) rise[k] = e;
        end
        for (int k = 0; k < N; k++)
            check($sformatf("rise_edge_%0d", k), rise[k], SYNC + 1 + DEB + DLY * (k + 1));

        // Debounce glitch.
        rst = 1'b1; tick(); rst = 1'b0;
        run(10);
        pll_locked_i = 1'b0; run(3); pll_locked_i = 1'b1;
        run(80);

        // Lock loss in RUN.
        pll_locked_i = 1'b0; tick(); pll_locked_i = 1'b1;
        run(80);

        // Software request in RUN.
        sw_rst_req_i = 1'b1; tick(); sw_rst_req_i = 1'b0;
        run(130);

        // Button press after domain 1 released.
        ext_rst_n_i = 1'b0; tick(); ext_rst_n_i = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            tick();
            if (rst_n_o == 4'b0011) found = 1;
        end
        check("reached_0011", found, 1);
        ext_rst_n_i = 1'b0; run(2); ext_rst_n_i = 1'b1;
        run(90);

        // Randomised glitches, requests and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 999) < 2);
            pll_locked_i = ($urandom_range(0, 99) >= 2);
            ext_rst_n_i  = ($urandom_range(0, 99) >= 1);
            sw_rst_req_i = ($urandom_range(0, 99) < 4);
            tick();
        end
        rst = 1'b0; pll_locked_i = 1'b1; ext_rst_n_i = 1'b1; sw_rst_req_i = 1'b0;

        // Simultaneous software request and lock loss seen in RUN.
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            tick();
            if (all_ready_o) found = 1;
        end
        check("reached_run", found, 1);
        pll_locked_i = 1'b0; tick();
        pll_locked_i = 1'b1; tick();
        sw_rst_req_i = 1'b1; tick();
        sw_rst_req_i = 1'b0;
        check("simul_cause", reset_cause_o, 2);
        run(60);

        // Drive the lock-loss counter into saturation.
        for (int i = 0; i < 300; i++) begin
            pll_locked_i = 1'b0; tick(); pll_locked_i = 1'b1;
            run(60);
        end
        check("lock_saturated", lock_loss_cnt_o, 255);

        run(3);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
